// File: rtl/monolith_perm_stream_tx.sv
// monolith_perm_stream_tx: buffers whole permutation states in a chunk FIFO and serialises each onto AXI-Stream.
// Optional MONOLITH_TX_PERF_CNT_EN builds the sent-state and stall counters; otherwise both ports read 0.
module monolith_perm_stream_tx #(
  parameter int C_M_AXIS_TDATA_WIDTH = 31,
  parameter int CHUNK_SIZE = 16,
  parameter int CHUNK_COUNT = 2
) (
  input  logic M_AXIS_ACLK,
  input  logic M_AXIS_ARESETN,
  input  logic [CHUNK_SIZE-1:0][C_M_AXIS_TDATA_WIDTH-1:0] chunk_in,
  input  logic chunk_valid,
  output logic chunk_ready,
  output logic M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic M_AXIS_TLAST,
  input  logic M_AXIS_TREADY,
  output logic busy,
  output logic [31:0] tx_chunk_cnt,
  output logic [31:0] tx_stall_cnt
);
  localparam int PW = CHUNK_COUNT > 1 ? $clog2(CHUNK_COUNT) : 1;
  localparam int CW = $clog2(CHUNK_COUNT + 1);
  localparam int BW = CHUNK_SIZE > 1 ? $clog2(CHUNK_SIZE) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [CHUNK_SIZE-1:0][C_M_AXIS_TDATA_WIDTH-1:0] mem [CHUNK_COUNT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic [BW-1:0] beat_idx;
  logic rst_q, push, pop, last, beat_hs;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(CHUNK_COUNT - 1) ? '0 : p + PW'(1);
  endfunction
  assign last = beat_idx == BW'(CHUNK_SIZE - 1);
  assign beat_hs = state == SEND && M_AXIS_TREADY;
  assign pop = beat_hs && last;
  // rst_q holds off enqueue until the first clock after reset release
  assign chunk_ready = rst_q && count < CW'(CHUNK_COUNT);
  assign push = chunk_valid && chunk_ready;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign M_AXIS_TSTRB = '1;
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) rst_q <= 1'b0;
    else rst_q <= 1'b1;
  always_ff @(posedge M_AXIS_ACLK)
    if (push) mem[wr_ptr] <= chunk_in;
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      beat_idx <= '0;
    end else begin
      count <= count_nx;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (beat_hs) beat_idx <= last ? '0 : beat_idx + BW'(1);
      if (pop) rd_ptr <= nxt(rd_ptr);
    end
  // back-to-back states stay in SEND so the stream has no bubble between packets
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = count != '0 ? SEND : IDLE;
    else if (pop) state_nx = count_nx != '0 ? SEND : IDLE;
  end
  always_comb begin
    M_AXIS_TVALID = state == SEND;
    M_AXIS_TLAST = state == SEND && last;
    M_AXIS_TDATA = mem[rd_ptr][beat_idx];
    busy = count != '0 || state == SEND;
  end
`ifdef MONOLITH_TX_PERF_CNT_EN
  logic [31:0] chunk_cnt_q, stall_cnt_q;
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) begin
      chunk_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) chunk_cnt_q <= chunk_cnt_q + 32'd1;
      if (M_AXIS_TVALID && !M_AXIS_TREADY) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  assign tx_chunk_cnt = chunk_cnt_q;
  assign tx_stall_cnt = stall_cnt_q;
`else
  assign tx_chunk_cnt = '0;
  assign tx_stall_cnt = '0;
`endif
endmodule

// File: doc/monolith_perm_stream_tx.md
Name: monolith_perm_stream_tx

Overview:
- Transmit-side counterpart to the AXI-Stream receive path of the Monolith hash IP.
- Accepts complete permutation states (CHUNK_SIZE words, loaded in parallel) into a chunk FIFO.
- Serializes each state onto an AXI-Stream master as CHUNK_SIZE beats, with TLAST on the final beat.
- Used as the stimulus/feeder source for the hash IP's slave port, and as the output stage of any block producing whole permutation states.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 31, width of one field element / one stream beat.
- CHUNK_SIZE, 16, words per permutation state (beats per packet).
- CHUNK_COUNT, 2, number of whole states the FIFO holds; any value >= 1, not required to be a power of two.

Ports:
- M_AXIS_ACLK  input  1  single clock for the whole block.
- M_AXIS_ARESETN  input  1  asynchronous, active-low reset.
- chunk_in  input  CHUNK_SIZE x C_M_AXIS_TDATA_WIDTH  parallel permutation state; word 0 is sent first.
- chunk_valid  input  1  chunk_in holds a state to enqueue.
- chunk_ready  output  1  FIFO can accept a state this cycle.
- M_AXIS_TVALID  output  1  beat valid.
- M_AXIS_TDATA  output  C_M_AXIS_TDATA_WIDTH  beat data.
- M_AXIS_TSTRB  output  C_M_AXIS_TDATA_WIDTH/8  byte strobes.
- M_AXIS_TLAST  output  1  last beat of a state.
- M_AXIS_TREADY  input  1  downstream ready.
- busy  output  1  FIFO non-empty or a packet is in flight.
- tx_chunk_cnt  output  32  states fully sent (feature-dependent).
- tx_stall_cnt  output  32  cycles with TVALID=1 and TREADY=0 (feature-dependent).

Behaviour:
- Reset (async assert, sync deassert inside block):
  - wr_ptr, rd_ptr, count and beat_idx = 0; FSM = IDLE.
  - TVALID = 0, TLAST = 0, busy = 0, counters = 0.
  - chunk_ready = 1 from the first clock after reset release.
  - Any partially sent state is discarded; no TLAST is emitted for it.
- Enqueue:
  - Occurs on chunk_valid && chunk_ready; all CHUNK_SIZE words are written into mem[wr_ptr].
  - wr_ptr increments, wrapping from CHUNK_COUNT-1 to 0; count increments.
- chunk_ready = (count < CHUNK_COUNT), registered-count based with no same-cycle bypass. When the FIFO is full, ready stays 0 even if a pop happens that cycle.
- FSM:
  - IDLE: TVALID = 0. If count != 0, go to SEND with beat_idx = 0. Minimum latency from enqueue into an empty FIFO to first TVALID is 2 cycles.
  - SEND: TVALID = 1, TDATA = mem[rd_ptr][beat_idx], TLAST = (beat_idx == CHUNK_SIZE-1).
    - On TVALID && TREADY when not last: beat_idx++.
    - On TVALID && TREADY when last: beat_idx = 0, rd_ptr wraps/increments, count decrements.
    - After the last beat: if count (post-update) != 0, stay in SEND and send the next state back-to-back with no bubble; else go to IDLE.
- AXIS stability: once TVALID = 1, TDATA and TLAST hold until the handshake. The rd slot is never written while it is being sent, since a write only targets a slot not occupied by unsent data.
- TSTRB is constant all-ones.
- Simultaneous enqueue and final-beat pop: count is unchanged, and both pointers advance.
- CHUNK_COUNT = 1: the block alternates fill and drain; chunk_ready stays 0 for the whole packet.
- busy = (count != 0) || (state == SEND).

Optional Feature:
- Macro: MONOLITH_TX_PERF_CNT_EN.
- Defined:
  - tx_chunk_cnt increments on each TLAST handshake.
  - tx_stall_cnt increments each cycle with TVALID && !TREADY.
  - Both counters are 32-bit, wrap at 2^32, and clear only on reset.
- Undefined: the counter registers are not built and both ports are tied to 0.

Test Plan:
- Reset, then idle 10 cycles -> TVALID = 0, chunk_ready = 1, busy = 0, counters = 0.
- Enqueue state words 0..15 (value = index + 0x100), TREADY held 1 -> TVALID rises 2 cycles after enqueue; 16 beats 0x100..0x10F; TLAST only on 0x10F; tx_chunk_cnt = 1.
- Enqueue 3 states back-to-back with TREADY = 0:
  - chunk_ready drops after 2 states; the third is held.
  - Raising TREADY streams 48 contiguous beats with TLAST at beats 15/31/47, no bubbles, in order.
- TREADY toggled pseudo-randomly over 2 states -> TDATA/TLAST never change while TVALID && !TREADY; tx_stall_cnt equals the count of stalled cycles.
- Assert ARESETN = 0 mid-packet (beat 7) -> outputs clear asynchronously; after release, a newly enqueued state starts at word 0 and no stale TLAST appears.
- FIFO full; enqueue attempted on the same cycle as the final-beat handshake -> enqueue rejected (chunk_ready = 0); accepted the next cycle; data intact.
